// File: rtl/d_flip_flop_asy_pkg.sv
// Shared defaults for the d_flip_flop_asy storage register.
// Instantiating blocks import this to size and reset their own flops consistently.
package d_flip_flop_asy_pkg;

  localparam int   DFF_DEFAULT_WIDTH = 32'sd1;
  localparam logic DFF_RESET_BIT     = 1'b0;

endpackage : d_flip_flop_asy_pkg

// File: rtl/d_flip_flop_asy_checker.sv
// Assertion-only companion for d_flip_flop_asy.
// Covers the q/qbar complement invariant, clear behaviour and one-edge data capture.
module d_flip_flop_asy_checker #(
  parameter int               WIDTH       = 32'sd1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             clear,
  input logic [WIDTH-1:0] d,
  input logic [WIDTH-1:0] q,
  input logic [WIDTH-1:0] qbar
);

  // Until the first clear, q is legitimately unknown, so the invariant is guarded.
  a_complement: assert property (@(posedge clk)
    !$isunknown(q) |-> ((q ^ qbar) == {WIDTH{1'b1}}))
    else $error("q/qbar complement broken");

  a_clear_loads_reset: assert property (@(posedge clk)
    clear |=> (q == RESET_VALUE))
    else $error("clear did not load reset value");

  a_capture_d: assert property (@(posedge clk)
    (!clear && !$isunknown(d)) |=> (q == $past(d)))
    else $error("d not captured on edge");

endmodule : d_flip_flop_asy_checker

// File: rtl/d_flip_flop_asy.sv
// Parameterisable D register with complementary output and synchronous clear.
// qbar is derived from the stored value only, so it moves in the same delta as q.
module d_flip_flop_asy
  import d_flip_flop_asy_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  generate
    if (WIDTH < 32'sd1) begin : g_bad_width
      $error("d_flip_flop_asy: WIDTH must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] q_r;

  // Storage register: clear takes priority over d at the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= d;
    end
  end

  assign q    = q_r;
  assign qbar = ~q_r;

  d_flip_flop_asy_checker #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_checker (
    .clk   (clk),
    .clear (clear),
    .d     (d),
    .q     (q),
    .qbar  (qbar)
  );

endmodule : d_flip_flop_asy

// File: tb/tb_d_flip_flop_asy.sv
// Self-checking bench for d_flip_flop_asy: default 1-bit instance and an 8-bit instance
// with a non-zero reset value, using timed sequences, a vector table and random stimulus.
module tb_d_flip_flop_asy;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       clear1;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [0:0] qbar1;
  logic       clear8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qbar8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       clr;
    logic [7:0] din;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[8];

  d_flip_flop_asy u_dut1 (
    .clk   (clk),
    .clear (clear1),
    .d     (d1),
    .q     (q1),
    .qbar  (qbar1)
  );

  d_flip_flop_asy #(
    .WIDTH       (8),
    .RESET_VALUE (RV8)
  ) u_dut8 (
    .clk   (clk),
    .clear (clear8),
    .d     (d8),
    .q     (q8),
    .qbar  (qbar8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic [0:0] exp_q);
    check({name, ".q"},    {7'd0, q1},    {7'd0, exp_q});
    check({name, ".qbar"}, {7'd0, qbar1}, {7'd0, ~exp_q});
  endtask

  task automatic check8(input string name, input logic [7:0] exp_q);
    check({name, ".q8"},    q8,    exp_q);
    check({name, ".qbar8"}, qbar8, ~exp_q);
  endtask

  initial begin
    logic [7:0] exp_q;
    logic [0:0] exp1;

    // Time 0: clear asserted on both instances, narrow d toggles every 2 ns.
    clear1 = 1'b1;
    d1     = 1'b0;
    clear8 = 1'b1;
    d8     = 8'h00;

    for (int k = 1; k <= 13; k++) begin
      #2;
      if (k == 3) begin
        check1("reset_capture", 1'b0);
        check8("wide_reset", RV8);
      end
      if (k >= 8 && k <= 12) check1("hold_between_edges", 1'b1);
      if (k == 13) check1("capture_zero_25ns", 1'b0);
      d1 = ~d1;
      if (k == 5) clear1 = 1'b0;
    end
    // t=26, d1 = 1

    #1 clear1 = 1'b1;   // 27
    #2 clear1 = 1'b0;   // 29
    #1 check1("clear_pulse_between_edges", 1'b0);  // 30
    #6 check1("capture_after_pulse", 1'b1);        // 36, edge 35 took d=1
    clear1 = 1'b1;
    #4 check1("sync_clear_holds", 1'b1);           // 40
    #6 check1("clear_priority_over_d", 1'b0);      // 46, edge 45 clear=1 d=1
    clear1 = 1'b0;

    // Vector table for the wide instance.
    vecs[0] = '{1'b1, 8'h3C, RV8};
    vecs[1] = '{1'b0, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF};
    vecs[3] = '{1'b1, 8'hFF, RV8};
    vecs[4] = '{1'b0, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 8'h5A, 8'h5A};
    vecs[6] = '{1'b1, 8'h00, RV8};
    vecs[7] = '{1'b0, 8'h81, 8'h81};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clear8 = vecs[i].clr;
      d8     = vecs[i].din;
      @(posedge clk);
      #1 check8($sformatf("vec%0d", i), vecs[i].exp_q);
    end

    // Random stimulus against the rule "next q = clear ? reset : d",
    // with d scrambled mid-cycle to confirm only edge values are captured.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      clear1 = ($urandom_range(0, 7) == 0);
      d1     = 1'($urandom);
      clear8 = ($urandom_range(0, 7) == 0);
      d8     = 8'($urandom);
      exp1   = clear1 ? 1'b0 : d1;
      exp_q  = clear8 ? RV8 : d8;
      @(posedge clk);
      #1;
      check1("rand1", exp1);
      check8("rand8", exp_q);
      check("invariant8", q8 ^ qbar8, 8'hFF);
      #2;
      d1 = ~d1;
      d8 = 8'($urandom);
      clear8 = ~clear8;
      clear1 = ~clear1;
      #1;
      check1("rand1_midcycle", exp1);
      check8("rand8_midcycle", exp_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_d_flip_flop_asy

// File: doc/d_flip_flop_asy.md
Name: d_flip_flop_asy

Overview:
- Parameterisable D-type storage register with a true output `q` and a complementary output `qbar`.
- Samples `d` on the rising edge of `clk`.
- `clear` is a synchronous, active-high reset.
- Leaf primitive for sequential datapaths, pipeline stages and control flags; instantiated wherever a clocked bit or vector with a complement is required.

Parameters:
- WIDTH, 1, number of data bits stored; must be >= 1.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into `q` when `clear` is sampled high.

Ports:
- clk    input   1      single clock; all state changes on its rising edge.
- clear  input   1      synchronous reset, active-high; sampled on the rising edge of `clk`.
- d      input   WIDTH  data input, sampled on the rising edge of `clk`.
- q      output  WIDTH  registered data.
- qbar   output  WIDTH  bitwise complement of `q`.

Behaviour:
- Reset and clock:
  - One clock, `clk`.
  - Reset is synchronous and active-high, on port `clear`.
  - No asynchronous path: a change on `clear` between edges has no effect on `q` until the next rising edge.
- At each rising edge of `clk`:
  - if `clear` = 1: `q` <= RESET_VALUE.
  - else: `q` <= `d`.
- `clear` has priority over `d` when both are active at the same edge.
- `qbar` = ~`q` at all times, derived combinationally from the stored `q` only, never from `d`.
  - `qbar` therefore changes in the same delta as `q`, with no extra cycle of latency.
- Latency: `d` appears on `q` one rising edge after it is sampled. No combinational path from `d` or `clear` to `q` or `qbar`.
- Reset values:
  - `q` = RESET_VALUE.
  - `qbar` = ~RESET_VALUE; with the default, `q`=0 and `qbar`=1 on every bit.
- Power-up before the first edge:
  - `q` and `qbar` are unknown in simulation; no initial-value assignment in RTL.
  - The system must apply `clear` for at least one rising edge before `q` is relied upon.
- `d` changing between edges is ignored. Only the value present at the rising edge is captured; glitches and multiple toggles within a cycle do not propagate.
- `clear` asserted mid-operation: `q` goes to RESET_VALUE at the next rising edge, regardless of `d`. The previous value is lost.
- `clear` deasserted: the first edge with `clear`=0 captures `d`.
- Width rule: all bits behave identically and independently. No arithmetic, no enable, no wrap-around.
- The invariant `q` ^ `qbar` == all-ones holds at every time after the first rising edge with known inputs.

Decomposition:
- Shared package: the default WIDTH constant (1) and a default reset-value constant (all zeros), for reuse by instantiating blocks.
- No sub-module; a single always block for `q` plus one continuous assignment for `qbar`.
- The bulk of the block's code is the parameter checks (WIDTH >= 1) and assertions for the `q`/`qbar` complement invariant and reset behaviour.

Test Plan:
- Timing for the scenarios below: clk period 10 ns with the first rising edge at 5 ns; `d` toggling every 2 ns starting from 0; `clear`=1 until 10 ns, then 0.
- Reset capture: at the 5 ns edge -> `q`=0, `qbar`=1, even though `d` is mid-toggle.
- Data capture after release: `d`=1 at the 15 ns edge -> `q`=1, `qbar`=0 from 15 ns. `d`=0 at the 25 ns edge -> `q`=0, `qbar`=1.
- Between-edge insensitivity: `d` toggles at 16, 18, 20, 22 ns -> `q` stays constant throughout 15–25 ns.
- Clear priority: `d`=1 and `clear`=1 at the same edge -> `q`=0, `qbar`=1. Pulsing `clear` high between edges only (e.g. 27–29 ns) -> no change to `q`.
- Synchronous-only reset: `clear` rises 1 ns after an edge where `q`=1 -> `q` holds 1 until the next edge, then becomes 0.
- Wide instance: WIDTH=8, RESET_VALUE=8'hA5.
  - `clear`=1 -> `q`=8'hA5, `qbar`=8'h5A.
  - `d`=8'h3C with `clear`=0 -> next edge `q`=8'h3C, `qbar`=8'hC3.
  - Complement invariant checked every cycle.
